// File: rtl/reg_csr_bank_pkg.sv
// reg_csr_bank_pkg
// Shared definitions for the CSR bank: register byte offsets, CTRL/STATUS bit
// positions, the clear-sweep state encoding and a byte-enable merge helper.
package reg_csr_bank_pkg;

  // Register byte offsets (word aligned)
  localparam int unsigned CTRL_OFFSET         = 32'h00;
  localparam int unsigned STATUS_OFFSET       = 32'h04;
  localparam int unsigned COUNT_OFFSET        = 32'h08;
  localparam int unsigned COMPARE_OFFSET      = 32'h0C;
  localparam int unsigned SCRATCH_BASE_OFFSET = 32'h10;

  // CTRL bit positions
  localparam int unsigned CTRL_CNT_EN_BIT = 0;
  localparam int unsigned CTRL_CLR_BIT    = 1;
  localparam int unsigned CTRL_IRQ_EN_BIT = 2;

  // STATUS bit positions
  localparam int unsigned STATUS_BUSY_BIT    = 0;
  localparam int unsigned STATUS_CMP_HIT_BIT = 1;

  // Clear-sweep FSM states
  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } sweep_state_e;

  // Replace only the bytes of old_val whose enable is set
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  be);
    logic [31:0] result;
    result = old_val;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) begin
        result[8*b +: 8] = new_val[8*b +: 8];
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/reg_csr_bank_sweep.sv
// reg_csr_bank_sweep
// Hardware clear sweep for the scratch bank. A start pulse launches a walk over
// every scratch index, one per cycle; busy is high for exactly NumScratch cycles.
// Ports:
//   clk_i     clock
//   rst_i     synchronous active-high reset
//   start_i   launch a sweep (only honoured while idle)
//   busy_o    sweep in progress
//   clr_en_o  clear scratch[idx_o] this cycle
//   idx_o     scratch index being cleared
module reg_csr_bank_sweep
  import reg_csr_bank_pkg::*;
#(
  parameter int NumScratch = 4,
  parameter int IdxW       = (NumScratch > 1) ? $clog2(NumScratch) : 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  output logic            busy_o,
  output logic            clr_en_o,
  output logic [IdxW-1:0] idx_o
);

  localparam logic [IdxW-1:0] LastIdx = IdxW'(NumScratch - 1);

  sweep_state_e    state_q, state_d;
  logic [IdxW-1:0] idx_q, idx_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Each SWEEP cycle clears the current index; leaving after the last one
  // makes the SWEEP dwell exactly NumScratch cycles.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    clr_en_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = SWEEP;
          idx_d   = '0;
        end
      end
      SWEEP: begin
        clr_en_o = 1'b1;
        if (idx_q == LastIdx) begin
          state_d = IDLE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  assign busy_o = (state_q == SWEEP);
  assign idx_o  = idx_q;

endmodule

// File: rtl/reg_csr_bank.sv
// reg_csr_bank
// Register-interface peripheral behind a TL-UL register adapter (AccessLatency 1).
// Holds CTRL/STATUS, a free-running COUNT with COMPARE interrupt and a bank of
// scratch registers that can be wiped by a hardware sweep.
// Ports:
//   clk_i    clock
//   rst_i    synchronous active-high reset
//   re_i     read strobe (single cycle)
//   we_i     write strobe (single cycle)
//   addr_i   word-aligned byte address, bits [1:0] ignored
//   wdata_i  write data
//   be_i     byte enables
//   busy_o   clear sweep in progress
//   rdata_o  read data, valid the cycle after re_i
//   error_o  access error, valid the cycle after re_i/we_i
//   irq_o    compare interrupt
module reg_csr_bank
  import reg_csr_bank_pkg::*;
#(
  parameter int          RegAw        = 8,
  parameter int          NumScratch   = 4,
  parameter logic [31:0] ResetCompare = 32'hFFFF_FFFF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             re_i,
  input  logic             we_i,
  input  logic [RegAw-1:0] addr_i,
  input  logic [31:0]      wdata_i,
  input  logic [3:0]       be_i,
  output logic             busy_o,
  output logic [31:0]      rdata_o,
  output logic             error_o,
  output logic             irq_o
);

  localparam int WordW       = RegAw - 2;
  localparam int IdxW        = (NumScratch > 1) ? $clog2(NumScratch) : 1;
  localparam int ScratchWord = int'(SCRATCH_BASE_OFFSET >> 2);
  localparam int ScratchEnd  = ScratchWord + NumScratch;

  logic [WordW-1:0] word_idx;
  logic [1:0]       unused_addr_lsbs;
  logic             is_ctrl, is_status, is_count, is_compare, is_scratch;
  logic [IdxW-1:0]  scr_idx;
  logic             access, acc_err, wr_ok;
  logic [31:0]      read_val;

  logic             cnt_en_q, irq_en_q, cmp_hit_q, irq_q, error_q;
  logic [31:0]      count_q, compare_q, rdata_q;
  logic [31:0]      scratch_q [NumScratch];

  logic             sweep_start, sweep_busy, sweep_clr;
  logic [IdxW-1:0]  sweep_idx;
  logic             cmp_set, cmp_clr;

  assign word_idx         = addr_i[RegAw-1:2];
  assign unused_addr_lsbs = addr_i[1:0];

  assign is_ctrl    = (word_idx == WordW'(CTRL_OFFSET >> 2));
  assign is_status  = (word_idx == WordW'(STATUS_OFFSET >> 2));
  assign is_count   = (word_idx == WordW'(COUNT_OFFSET >> 2));
  assign is_compare = (word_idx == WordW'(COMPARE_OFFSET >> 2));
  // One extra bit so the end bound fits even when the bank fills the map
  assign is_scratch = ({1'b0, word_idx} >= (WordW+1)'(ScratchWord)) &&
                      ({1'b0, word_idx} <  (WordW+1)'(ScratchEnd));
  assign scr_idx    = IdxW'(word_idx - WordW'(ScratchWord));

  // Any access during a sweep is a protocol violation and is dropped
  assign access  = re_i | we_i;
  assign acc_err = sweep_busy |
                   ~(is_ctrl | is_status | is_count | is_compare | is_scratch);
  assign wr_ok   = we_i & ~acc_err;

  assign sweep_start = wr_ok & is_ctrl & be_i[0] & wdata_i[CTRL_CLR_BIT];
  assign cmp_set     = cnt_en_q & (count_q == compare_q);
  assign cmp_clr     = wr_ok & is_status & be_i[0] & wdata_i[STATUS_CMP_HIT_BIT];

  reg_csr_bank_sweep #(
    .NumScratch (NumScratch),
    .IdxW       (IdxW)
  ) u_sweep (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .start_i  (sweep_start),
    .busy_o   (sweep_busy),
    .clr_en_o (sweep_clr),
    .idx_o    (sweep_idx)
  );

  // Read mux over the pre-update register values
  always_comb begin
    read_val = '0;
    if (is_ctrl) begin
      read_val[CTRL_CNT_EN_BIT] = cnt_en_q;
      read_val[CTRL_IRQ_EN_BIT] = irq_en_q;
    end else if (is_status) begin
      read_val[STATUS_BUSY_BIT]    = sweep_busy;
      read_val[STATUS_CMP_HIT_BIT] = cmp_hit_q;
    end else if (is_count) begin
      read_val = count_q;
    end else if (is_compare) begin
      read_val = compare_q;
    end else if (is_scratch) begin
      for (int i = 0; i < NumScratch; i++) begin
        if (scr_idx == IdxW'(i)) begin
          read_val = scratch_q[i];
        end
      end
    end
  end

  // Control, counter, status and response registers. A software COUNT write
  // beats the increment; a hit set beats a same-cycle W1C.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_en_q  <= 1'b0;
      irq_en_q  <= 1'b0;
      cmp_hit_q <= 1'b0;
      irq_q     <= 1'b0;
      count_q   <= '0;
      compare_q <= ResetCompare;
      rdata_q   <= '0;
      error_q   <= 1'b0;
    end else begin
      if (access) begin
        error_q <= acc_err;
      end
      if (re_i) begin
        rdata_q <= acc_err ? 32'h0 : read_val;
      end
      if (wr_ok && is_ctrl && be_i[0]) begin
        cnt_en_q <= wdata_i[CTRL_CNT_EN_BIT];
        irq_en_q <= wdata_i[CTRL_IRQ_EN_BIT];
      end
      if (wr_ok && is_count) begin
        count_q <= merge_bytes(count_q, wdata_i, be_i);
      end else if (cnt_en_q) begin
        count_q <= count_q + 32'd1;
      end
      if (wr_ok && is_compare) begin
        compare_q <= merge_bytes(compare_q, wdata_i, be_i);
      end
      cmp_hit_q <= cmp_set | (cmp_hit_q & ~cmp_clr);
      irq_q     <= cmp_hit_q & irq_en_q;
    end
  end

  // Scratch bank; writes cannot collide with the sweep since they are
  // rejected while it runs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NumScratch; i++) begin
        scratch_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NumScratch; i++) begin
        if (sweep_clr && (sweep_idx == IdxW'(i))) begin
          scratch_q[i] <= '0;
        end else if (wr_ok && is_scratch && (scr_idx == IdxW'(i))) begin
          scratch_q[i] <= merge_bytes(scratch_q[i], wdata_i, be_i);
        end
      end
    end
  end

  assign busy_o  = sweep_busy;
  assign rdata_o = rdata_q;
  assign error_o = error_q;
  assign irq_o   = irq_q;

endmodule

// File: tb/tb_reg_csr_bank.sv
// tb_reg_csr_bank
// Self-checking bench for reg_csr_bank: directed scenarios with literal
// expectations followed by randomized traffic, all compared every cycle
// against a behavioural model of the register map.
module tb_reg_csr_bank;

  localparam int NUM = 4;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        re_i = 1'b0;
  logic        we_i = 1'b0;
  logic [7:0]  addr_i = '0;
  logic [31:0] wdata_i = '0;
  logic [3:0]  be_i = '0;
  logic        busy_o;
  logic [31:0] rdata_o;
  logic        error_o;
  logic        irq_o;

  int n_compared = 0;
  int n_mismatched = 0;

  reg_csr_bank #(
    .RegAw        (8),
    .NumScratch   (NUM),
    .ResetCompare (32'hFFFF_FFFF)
  ) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .re_i    (re_i),
    .we_i    (we_i),
    .addr_i  (addr_i),
    .wdata_i (wdata_i),
    .be_i    (be_i),
    .busy_o  (busy_o),
    .rdata_o (rdata_o),
    .error_o (error_o),
    .irq_o   (irq_o)
  );

  always #5 clk_i = ~clk_i;

  // Behavioural model state
  bit          model_live = 0;
  bit          m_cnt_en, m_irq_en, m_hit, m_irq, m_err;
  logic [31:0] m_count, m_compare, m_rdata;
  logic [31:0] m_scratch [NUM];
  int          m_sweep_left;

  function automatic logic [31:0] mergeBytes(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  b);
    logic [31:0] r;
    r = old_v;
    for (int k = 0; k < 4; k++) if (b[k]) r[k*8 +: 8] = new_v[k*8 +: 8];
    return r;
  endfunction

  function automatic logic [31:0] modelRead(input int w);
    case (w)
      0: return {29'b0, m_irq_en, 1'b0, m_cnt_en};
      1: return {30'b0, m_hit, (m_sweep_left != 0)};
      2: return m_count;
      3: return m_compare;
      default: return m_scratch[w-4];
    endcase
  endfunction

  // Model update: every next value is computed from the values before the edge
  int          w_idx;
  bit          bad, wr, start, n_cnt_en, n_irq_en, n_hit;
  logic [31:0] n_count, n_compare;
  always @(posedge clk_i) begin
    if (rst_i) begin
      model_live = 1;
      m_cnt_en = 0; m_irq_en = 0; m_hit = 0; m_irq = 0; m_err = 0;
      m_count = 0; m_compare = 32'hFFFF_FFFF; m_rdata = 0; m_sweep_left = 0;
      for (int i = 0; i < NUM; i++) m_scratch[i] = 0;
    end else if (model_live) begin
      w_idx = int'(addr_i >> 2);
      bad = (m_sweep_left != 0) || (w_idx >= 4 + NUM);
      wr = we_i && !bad;
      if (re_i || we_i) m_err = bad;
      if (re_i) m_rdata = bad ? 32'h0 : modelRead(w_idx);
      n_cnt_en = m_cnt_en; n_irq_en = m_irq_en; n_hit = m_hit;
      n_compare = m_compare;
      n_count = m_cnt_en ? m_count + 32'd1 : m_count;
      start = 0;
      m_irq = m_hit && m_irq_en;
      if (wr) begin
        case (w_idx)
          0: if (be_i[0]) begin
               n_cnt_en = wdata_i[0]; n_irq_en = wdata_i[2]; start = wdata_i[1];
             end
          1: if (be_i[0] && wdata_i[1]) n_hit = 0;
          2: n_count = mergeBytes(m_count, wdata_i, be_i);
          3: n_compare = mergeBytes(m_compare, wdata_i, be_i);
          default: m_scratch[w_idx-4] = mergeBytes(m_scratch[w_idx-4], wdata_i, be_i);
        endcase
      end
      if (m_cnt_en && m_count == m_compare) n_hit = 1;
      if (m_sweep_left != 0) begin
        m_scratch[NUM - m_sweep_left] = 0;
        m_sweep_left--;
      end
      if (start) m_sweep_left = NUM;
      m_cnt_en = n_cnt_en; m_irq_en = n_irq_en; m_hit = n_hit;
      m_count = n_count; m_compare = n_compare;
    end
  end

  // Cycle-by-cycle comparison of all outputs against the model
  always @(posedge clk_i) begin
    #1;
    if (model_live) begin
      n_compared += 4;
      if (rdata_o !== m_rdata) begin
        n_mismatched++;
        $display("[TB] FAIL model_rdata: got %h expected %h at %0t", rdata_o, m_rdata, $time);
      end
      if (error_o !== m_err) begin
        n_mismatched++;
        $display("[TB] FAIL model_error: got %b expected %b at %0t", error_o, m_err, $time);
      end
      if (busy_o !== (m_sweep_left != 0)) begin
        n_mismatched++;
        $display("[TB] FAIL model_busy: got %b expected %b at %0t", busy_o, (m_sweep_left != 0), $time);
      end
      if (irq_o !== m_irq) begin
        n_mismatched++;
        $display("[TB] FAIL model_irq: got %b expected %b at %0t", irq_o, m_irq, $time);
      end
    end
  end

  // Drive one access at the falling edge; return just after the response edge
  task automatic applyStimulus(input logic r, input logic w, input logic [7:0] a,
                               input logic [31:0] d, input logic [3:0] b);
    @(negedge clk_i);
    re_i = r; we_i = w; addr_i = a; wdata_i = d; be_i = b;
    @(posedge clk_i);
    #1;
    re_i = 1'b0; we_i = 1'b0;
  endtask

  task automatic idleCycle();
    @(negedge clk_i);
    @(posedge clk_i);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  int          busy_cycles;
  logic [31:0] d;
  logic [7:0]  a;
  int          op, pick;

  initial begin
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    $display("[TB] reset released");

    // Reset values
    applyStimulus(1, 0, 8'h0C, 0, 4'hF);
    checkOutput("rst_compare", rdata_o, 32'hFFFF_FFFF);
    checkOutput("rst_compare_err", {31'b0, error_o}, 0);
    applyStimulus(1, 0, 8'h00, 0, 4'hF);
    checkOutput("rst_ctrl", rdata_o, 0);

    // Byte-enable merge into scratch[1]
    applyStimulus(0, 1, 8'h14, 32'hA5A5_A5A5, 4'b0101);
    applyStimulus(1, 0, 8'h14, 0, 4'hF);
    checkOutput("scratch_merge", rdata_o, 32'h00A5_00A5);

    // Counter wrap, compare hit and delayed interrupt
    applyStimulus(0, 1, 8'h08, 32'hFFFF_FFFE, 4'hF);
    applyStimulus(0, 1, 8'h0C, 32'hFFFF_FFFF, 4'hF);
    applyStimulus(0, 1, 8'h00, 32'h5, 4'hF);
    idleCycle();
    idleCycle();
    checkOutput("irq_before_hit", {31'b0, irq_o}, 0);
    applyStimulus(1, 0, 8'h04, 0, 4'hF);
    checkOutput("hit_status", rdata_o, 32'h2);
    checkOutput("irq_after_hit", {31'b0, irq_o}, 1);
    applyStimulus(1, 0, 8'h08, 0, 4'hF);
    checkOutput("count_wrapped", rdata_o, 32'h1);

    // Stop and clear the hit
    applyStimulus(0, 1, 8'h00, 32'h0, 4'hF);
    applyStimulus(0, 1, 8'h04, 32'h2, 4'hF);
    applyStimulus(1, 0, 8'h04, 0, 4'hF);
    checkOutput("hit_cleared", rdata_o, 0);

    // W1C in the same cycle as a new hit: the set wins
    applyStimulus(0, 1, 8'h08, 32'h10, 4'hF);
    applyStimulus(0, 1, 8'h0C, 32'h12, 4'hF);
    applyStimulus(0, 1, 8'h00, 32'h5, 4'hF);
    idleCycle();
    idleCycle();
    applyStimulus(0, 1, 8'h04, 32'h2, 4'hF);
    applyStimulus(1, 0, 8'h04, 0, 4'hF);
    checkOutput("set_beats_w1c", rdata_o, 32'h2);
    applyStimulus(0, 1, 8'h00, 32'h4, 4'hF);
    applyStimulus(0, 1, 8'h04, 32'h2, 4'hF);
    checkOutput("irq_still_high", {31'b0, irq_o}, 1);
    applyStimulus(1, 0, 8'h04, 0, 4'hF);
    checkOutput("hit_off", rdata_o, 0);
    checkOutput("irq_fell", {31'b0, irq_o}, 0);

    // Clear sweep over a fully populated bank
    for (int i = 0; i < NUM; i++)
      applyStimulus(0, 1, 8'(8'h10 + 4*i), 32'h1111_1111 * (i + 1), 4'hF);
    applyStimulus(1, 0, 8'h18, 0, 4'hF);
    checkOutput("scratch2_loaded", rdata_o, 32'h3333_3333);
    applyStimulus(0, 1, 8'h00, 32'h2, 4'hF);
    busy_cycles = int'(busy_o);
    applyStimulus(1, 0, 8'h10, 0, 4'hF);
    checkOutput("busy_access_err", {31'b0, error_o}, 1);
    busy_cycles += int'(busy_o);
    for (int i = 0; i < 4; i++) begin
      idleCycle();
      busy_cycles += int'(busy_o);
    end
    checkOutput("busy_length", busy_cycles, NUM);
    for (int i = 0; i < NUM; i++) begin
      applyStimulus(1, 0, 8'(8'h10 + 4*i), 0, 4'hF);
      checkOutput($sformatf("swept_%0d", i), rdata_o, 0);
    end

    // Unmapped accesses
    applyStimulus(1, 0, 8'hF0, 0, 4'hF);
    checkOutput("unmapped_rd_err", {31'b0, error_o}, 1);
    checkOutput("unmapped_rdata", rdata_o, 0);
    applyStimulus(0, 1, 8'hF0, 32'hFFFF_FFFF, 4'hF);
    checkOutput("unmapped_wr_err", {31'b0, error_o}, 1);
    applyStimulus(1, 0, 8'h10, 0, 4'hF);
    checkOutput("unmapped_no_effect", rdata_o, 0);
    checkOutput("mapped_rd_ok", {31'b0, error_o}, 0);

    // Randomized traffic checked by the model every cycle
    for (int n = 0; n < 1500; n++) begin
      pick = int'($urandom_range(0, 99));
      if (pick < 2) begin
        @(negedge clk_i);
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
      end else begin
        op = int'($urandom_range(0, 2));
        if ($urandom_range(0, 7) == 0) a = 8'($urandom);
        else a = 8'({$urandom_range(0, 7), 2'($urandom)});
        d = $urandom;
        if ((a >> 2) == 0 && $urandom_range(0, 9) != 0) d[1] = 1'b0;
        if ((a >> 2) == 3 && $urandom_range(0, 2) == 0) d = m_count + $urandom_range(0, 6);
        if (op == 0) idleCycle();
        else applyStimulus(op == 1, op == 2, a, d, 4'($urandom));
      end
    end

    repeat (NUM + 2) idleCycle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/reg_csr_bank.md
Name: reg_csr_bank

Overview:
- Register-interface peripheral placed directly downstream of the TL-UL register adapter, built with that adapter's AccessLatency = 1.
- Consumes the adapter's re/we/addr/wdata/be strobes and returns rdata/error one cycle later.
- Drives busy back to the adapter.
- Implements a control/status pair, a free-running compare counter with interrupt, and a bank of scratch registers with a hardware clear sweep.

Parameters:
- RegAw, 8: register address width; must match the adapter.
- NumScratch, 4: number of scratch registers; legal range 1..(2^RegAw-16)/4.
- ResetCompare, 32'hFFFF_FFFF: reset value of COMPARE.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous, active-high reset
- re_i  in  1  read strobe, single cycle
- we_i  in  1  write strobe, single cycle
- addr_i  in  RegAw  word-aligned byte address
- wdata_i  in  32  write data
- be_i  in  4  byte enables
- busy_o  out  1  clear sweep in progress
- rdata_o  out  32  read data, valid the cycle after re_i
- error_o  out  1  access error, valid the cycle after re_i/we_i
- irq_o  out  1  compare interrupt

Behaviour:
- Interface: one clock (clk_i); reset rst_i is synchronous and active-high.
- Reset: rdata_o=0, error_o=0, busy_o=0, irq_o=0; all registers 0 except COMPARE=ResetCompare; FSM in IDLE.
- Decode uses addr_i[RegAw-1:2]; addr_i[1:0] ignored. re_i and we_i are never asserted together.
- Register map (byte offsets):
  - 0x00 CTRL: bit0 CNT_EN, bit1 CLR (write-1 pulse, reads 0), bit2 IRQ_EN.
  - 0x04 STATUS: bit0 SWEEP_BUSY (RO), bit1 CMP_HIT (W1C).
  - 0x08 COUNT: RW.
  - 0x0C COMPARE: RW.
  - 0x10+4*i SCRATCH[i], for i < NumScratch: RW.
- Byte enables: COUNT, COMPARE and SCRATCH merge per byte. CTRL/STATUS act only when be_i[0]=1.
- Response latency is 1 cycle:
  - rdata_o is registered on re_i and returns the register value at the access cycle, before any same-cycle update; otherwise it holds.
  - error_o is registered on re_i|we_i; otherwise it holds.
- Unmapped address: error_o=1, rdata_o=0, write has no effect.
- Access while busy_o=1 (protocol violation, since the adapter stalls on busy): error_o=1, ignored.
- COUNT:
  - Increments by 1 each cycle when CNT_EN=1; wraps 32'hFFFF_FFFF -> 0.
  - Software write in the same cycle wins: merged value loaded, no increment that cycle.
- CMP_HIT:
  - Set when CNT_EN=1 and count_q==COMPARE (compares the pre-increment value).
  - A set in the same cycle as a W1C leaves it at 1 (set wins).
- irq_o = registered (CMP_HIT & IRQ_EN), i.e. one cycle after the flop update.
- Sweep FSM, states IDLE and SWEEP:
  - IDLE->SWEEP on a CTRL write with be_i[0]=1 and wdata_i[1]=1; index=0.
  - In SWEEP, SCRATCH[index] is cleared each cycle and index increments.
  - SWEEP->IDLE after index==NumScratch-1 is cleared.
  - busy_o = (state==SWEEP), registered. It is high exactly NumScratch cycles, starting the cycle after the CLR write.
  - The same CTRL write also updates CNT_EN/IRQ_EN.
- Reset mid-sweep returns to IDLE with busy_o=0 next cycle. Counter and status continue to operate during a sweep.

Decomposition:
- Package reg_csr_bank_pkg:
  - register offset constants (CTRL, STATUS, COUNT, COMPARE, SCRATCH_BASE);
  - CTRL/STATUS bit indices;
  - sweep state enum (IDLE, SWEEP);
  - byte-merge function (old, new, be).
- One natural sub-module, reg_csr_bank_sweep: FSM, index counter and busy flop; outputs a clear-enable and index.
- Counter, decode and response flops stay in the top.

Test Plan:
- Reset, then read 0x0C -> next cycle rdata_o=32'hFFFF_FFFF, error_o=0; read 0x00 -> 0.
- SCRATCH[1]=0, write 0x14 with wdata=32'hA5A5_A5A5, be=4'b0101, then read -> 32'h00A5_00A5.
- Write COUNT=32'hFFFF_FFFE, COMPARE=32'hFFFF_FFFF, CTRL=3'b101 -> CMP_HIT set, COUNT wraps to 0, irq_o=1 one cycle after CMP_HIT sets.
- With CNT_EN=1 and COUNT==COMPARE, write STATUS=2 in the hit cycle -> CMP_HIT remains 1. Then clear it with CNT_EN=0 -> 0, and irq_o falls.
- NumScratch=4, all scratch nonzero, write CTRL=2 -> busy_o high exactly 4 cycles, then all scratch read 0. A re_i forced during busy -> error_o=1.
- Read 0xF0 -> error_o=1, rdata_o=0. Write 0xF0 -> error_o=1, no register changes.
